// File: rtl/dot_peak_search_pkg.sv
// Shared definitions for the dot-product peak search: FSM state encoding and
// the width of a full-precision complex power.
package dot_peak_search_pkg;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  // i*i + q*q for two signed bits-wide operands never needs more than 2*bits+1 bits.
  function automatic int unsigned power_width(input int unsigned bits);
    return 2 * bits + 1;
  endfunction

endpackage

// File: rtl/dot_peak_search_cpx_power.sv
// Stage 1 of the peak search: registers i*i + q*q at full precision together
// with the frame index and last-of-frame flag of the accepted product.
module cpx_power
  import dot_peak_search_pkg::*;
#(
  parameter int unsigned bits       = 24,
  parameter int unsigned index_bits = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_i,
  input  logic signed [bits-1:0]        i_i,
  input  logic signed [bits-1:0]        q_i,
  input  logic [index_bits-1:0]         index_i,
  input  logic                          last_i,
  output logic                          valid_o,
  output logic [power_width(bits)-1:0]  power_o,
  output logic [index_bits-1:0]         index_o,
  output logic                          last_o
);

  localparam int unsigned PW = power_width(bits);

  logic signed [2*bits-1:0] i_ext, q_ext, ii_sq, qq_sq;
  logic [PW-1:0]            power_d;

  // Squares are never negative, so each fits the signed 2*bits product and
  // can be zero-extended before the sum.
  always_comb begin
    i_ext   = {{bits{i_i[bits-1]}}, i_i};
    q_ext   = {{bits{q_i[bits-1]}}, q_i};
    ii_sq   = i_ext * i_ext;
    qq_sq   = q_ext * q_ext;
    power_d = {1'b0, ii_sq} + {1'b0, qq_sq};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      power_o <= '0;
      index_o <= '0;
      last_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      power_o <= power_d;
      index_o <= index_i;
      last_o  <= valid_i && last_i;
    end
  end

endmodule

// File: rtl/dot_peak_search.sv
// Finds the frame position of the largest i*i+q*q over a frame of dot products
// and presents it on a valid/ready result port; input is stalled until taken.
module dot_peak_search
  import dot_peak_search_pkg::*;
#(
  parameter int unsigned i_bits     = 24,
  parameter int unsigned q_bits     = 24,
  parameter int unsigned frame_len  = 64,
  parameter int unsigned index_bits = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            m_axis_product_tvalid,
  input  logic signed [i_bits-1:0]        i,
  input  logic signed [q_bits-1:0]        q,
  output logic                            s_axis_product_tready,
  input  logic                            m_axis_peak_tready,
  output logic                            s_axis_peak_tvalid,
  output logic [index_bits-1:0]           peak_index,
  output logic [power_width(i_bits)-1:0]  peak_power
);

  localparam int unsigned           PW         = power_width(i_bits);
  localparam logic [index_bits-1:0] LAST_INDEX = index_bits'(frame_len - 1);

  logic [0:0]            state_q, state_d;
  logic [index_bits-1:0] index_q, index_d;
  logic                  accept, accept_last, peak_hs;

  logic                  s1_valid, s1_last;
  logic [PW-1:0]         s1_power;
  logic [index_bits-1:0] s1_index;

  logic [PW-1:0]         max_power_q, max_power_d;
  logic [index_bits-1:0] max_index_q, max_index_d;
  logic                  s2_last_q;

  logic                  peak_valid_q;
  logic [index_bits-1:0] peak_index_q;
  logic [PW-1:0]         peak_power_q;

  assign s_axis_product_tready = (state_q == ACCUM);
  assign accept                = m_axis_product_tvalid && s_axis_product_tready;
  assign accept_last           = accept && (index_q == LAST_INDEX);
  assign peak_hs               = peak_valid_q && m_axis_peak_tready;

  cpx_power #(
    .bits       (i_bits),
    .index_bits (index_bits)
  ) u_cpx_power (
    .clk     (clk),
    .reset   (reset),
    .valid_i (accept),
    .i_i     (i),
    .q_i     (q),
    .index_i (index_q),
    .last_i  (accept_last),
    .valid_o (s1_valid),
    .power_o (s1_power),
    .index_o (s1_index),
    .last_o  (s1_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    max_power_d = max_power_q;
    max_index_d = max_index_q;

    if (accept) index_d = accept_last ? '0 : index_q + index_bits'(1);

    if (accept_last)  state_d = HOLD;
    else if (peak_hs) state_d = ACCUM;

    // Index 0 restarts the search; strict compare keeps the earliest of equal peaks.
    if (peak_hs) begin
      max_power_d = '0;
      max_index_d = '0;
    end else if (s1_valid && (s1_index == '0 || s1_power > max_power_q)) begin
      max_power_d = s1_power;
      max_index_d = s1_index;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      index_q      <= '0;
      max_power_q  <= '0;
      max_index_q  <= '0;
      s2_last_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_index_q <= '0;
      peak_power_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      max_power_q <= max_power_d;
      max_index_q <= max_index_d;
      s2_last_q   <= s1_valid && s1_last;
      if (s2_last_q) begin
        peak_valid_q <= 1'b1;
        peak_index_q <= max_index_q;
        peak_power_q <= max_power_q;
      end else if (peak_hs) begin
        peak_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis_peak_tvalid = peak_valid_q;
  assign peak_index         = peak_index_q;
  assign peak_power         = peak_power_q;

endmodule

// File: doc/dot_peak_search.md
DOT_PEAK_SEARCH -- requirements
Module: dot_peak_search

Interface
REQ-001 The block SHALL have parameter i_bits, default 24, meaning the signed width of the dot-product I input.
REQ-002 The block SHALL have parameter q_bits, default 24, meaning the signed width of the dot-product Q input; it SHALL equal i_bits.
REQ-003 The block SHALL have parameter frame_len, default 64, meaning the number of products per search frame (2..65536).
REQ-004 The block SHALL have parameter index_bits, default 6, meaning the width of the frame index; it SHALL equal clog2(frame_len).
REQ-005 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous active-high reset.
REQ-007 Port m_axis_product_tvalid: input, 1 bit, an upstream dot product is valid.
REQ-008 Port i: input, i_bits, signed dot-product I.
REQ-009 Port q: input, q_bits, signed dot-product Q.
REQ-010 Port s_axis_product_tready: output, 1 bit, the block accepts a product this cycle.
REQ-011 Port m_axis_peak_tready: input, 1 bit, downstream accepts the peak result.
REQ-012 Port s_axis_peak_tvalid: output, 1 bit, the peak result is valid.
REQ-013 Port peak_index: output, index_bits, frame position (0-based) of the maximum power.
REQ-014 Port peak_power: output, 2*i_bits+1, unsigned, i*i+q*q of the peak.

Function
REQ-015 A product SHALL be accepted on a rising edge where m_axis_product_tvalid and s_axis_product_tready are both high.
REQ-016 Stage 1 SHALL register power = i*i + q*q (full width, no truncation), the frame index and a last flag one cycle after acceptance.
REQ-017 Stage 2 SHALL update the running maximum when the stage-1 power is strictly greater than the stored maximum, or when the index is 0.
REQ-018 On ties, the block SHALL keep the earliest index.
REQ-019 The index counter SHALL increment per accepted product and SHALL wrap from frame_len-1 to 0.
REQ-020 The FSM SHALL have states ACCUM and HOLD.
REQ-021 In ACCUM, s_axis_product_tready SHALL be high.
REQ-022 Acceptance of index frame_len-1 SHALL move the FSM to HOLD on the same edge.
REQ-023 In HOLD, s_axis_product_tready SHALL be low.
REQ-024 If the last product is accepted on edge k, s_axis_peak_tvalid SHALL rise after edge k+2 with the final peak_index and peak_power.
REQ-025 s_axis_peak_tvalid, peak_index and peak_power SHALL stay stable until m_axis_peak_tready is high.
REQ-026 On the edge where s_axis_peak_tvalid and m_axis_peak_tready are both high, s_axis_peak_tvalid SHALL drop, the FSM SHALL return to ACCUM, and the running maximum SHALL clear.
REQ-027 Gaps in m_axis_product_tvalid SHALL stall the frame without affecting the result.
REQ-028 Power of i = -2^(i_bits-1), q = -2^(i_bits-1) SHALL be 2^(2*i_bits-1) exactly.

Reset
REQ-029 While reset is high on an edge, the FSM SHALL go to ACCUM and the index and the running maximum SHALL clear.
REQ-030 While reset is high on an edge, both pipeline valid bits, s_axis_peak_tvalid, peak_index and peak_power SHALL clear to 0.
REQ-031 s_axis_product_tready SHALL be high from the first cycle after reset.
REQ-032 Reset mid-frame or in HOLD SHALL discard the partial frame and any unaccepted result.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the power-width function 2*bits+1.
REQ-034 One sub-module, cpx_power (registered i*i+q*q), SHALL implement stage 1.

Verification
REQ-035 frame_len=4, (i,q) = (1,0),(3,4),(0,2),(-3,-4) back-to-back -> peak_index=1, peak_power=25 (tie kept first), tvalid high 2 cycles after the last product.
REQ-036 Hold m_axis_peak_tready low for 5 cycles -> s_axis_product_tready low, result stable; on tready high, next frame accepted the following cycle.
REQ-037 i=q=-2^23 at index 2 -> peak_power=2^47, peak_index=2.
REQ-038 Random tvalid gaps over a 64-sample frame -> result matches the reference model.
REQ-039 Assert reset at index 30 -> outputs 0; the next full frame reports a correct peak with no residue from the aborted frame.
REQ-040 All-zero frame -> peak_index=0, peak_power=0.
